// File: rtl/ntt_pkg.sv
// NTT shared constants and the zeta loader state encoding.
// Optional feature macro used by zeta_loader: ZETA_RANGE_CHECK_EN.
package ntt_pkg;

    localparam int NTT_STAGE_CNT = 7;
    localparam int DATA_WIDTH    = 12;
    localparam int Q             = 3329;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/zeta_idx_decode.sv
// Flat zeta index -> {one-hot stage, offset within stage bank}.
// stage = floor(log2 idx), offset = idx with its leading one cleared.
module zeta_idx_decode #(
    parameter int STAGE_CNT = 3
) (
    input  logic [STAGE_CNT-1:0] idx,
    output logic [STAGE_CNT-1:0] stage_oh,
    output logic [STAGE_CNT-2:0] offset
);

    logic [STAGE_CNT-1:0] off_full;

    // Priority encode: the highest set bit of idx wins.
    always_comb begin
        stage_oh = '0;
        off_full = '0;
        for (int unsigned i = 0; i < STAGE_CNT; i++) begin
            if (idx[i]) begin
                stage_oh    = '0;
                stage_oh[i] = 1'b1;
                off_full    = idx;
                off_full[i] = 1'b0;
            end
        end
        offset = off_full[STAGE_CNT-2:0];
    end

endmodule

// File: rtl/zeta_loader.sv
// Zeta loader: scatters a flat valid/ready stream of twiddle factors into
// per-stage zeta RAM banks as one-hot registered write strobes.
// Optional: ZETA_RANGE_CHECK_EN builds the s_data >= Q sticky error flag;
// without it err is tied low.
module zeta_loader
    import ntt_pkg::*;
#(
    parameter int STAGE_CNT = NTT_STAGE_CNT,
    parameter int WIDTH     = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic [STAGE_CNT-1:0] wr_en,
    output logic [STAGE_CNT-2:0] wr_addr,
    output logic [WIDTH-1:0]     wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    loader_state_t        state_q, state_d;
    logic [STAGE_CNT-1:0] idx_q, idx_d;
    logic [STAGE_CNT-1:0] wr_en_q, wr_en_d;
    logic [STAGE_CNT-2:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [STAGE_CNT-1:0] dec_oh;
    logic [STAGE_CNT-2:0] dec_off;
    logic                 accept;
    logic                 load_req;

    zeta_idx_decode #(
        .STAGE_CNT (STAGE_CNT)
    ) u_dec (
        .idx      (idx_q),
        .stage_oh (dec_oh),
        .offset   (dec_off)
    );

    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign accept   = s_valid & s_ready;
    assign load_req = start & (state_q != LOAD);

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // State, index and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= STAGE_CNT'(1);
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state and write generation; strobe is only set on an accept.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = STAGE_CNT'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = dec_oh;
                    wr_addr_d = dec_off;
                    wr_data_d = s_data;
                    // Leaving on the last index keeps idx from wrapping.
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + STAGE_CNT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ZETA_RANGE_CHECK_EN
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

    logic err_q, err_d;

    // Sticky out-of-range flag, cleared by a new load request.
    always_comb begin
        err_d = err_q;
        if (load_req) begin
            err_d = 1'b0;
        end else if (accept && (s_data >= Q_W)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_load_req;
    assign unused_load_req = load_req;
    assign err             = 1'b0;
`endif

endmodule

// File: doc/zeta_loader.md
Name: zeta_loader

Overview:
- Write-side counterpart of the per-stage zeta ROM banks: accepts a flat stream of twiddle factors over valid/ready and scatters them as one-hot write strobes into the per-stage zeta RAM banks.
- Stage s bank holds 2^s entries; flat index k (1 .. 2^STAGE_CNT-1) maps to stage = floor(log2 k), offset = k - 2^stage.
- Sits between the host/config interface and the NTT zeta storage; runs once after reset or on any reload request, before NTT operation.

Parameters:
STAGE_CNT, NTT_STAGE_CNT, number of NTT stages / zeta banks
WIDTH, DATA_WIDTH, zeta word width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle load request
s_valid  input  1  stream word valid
s_ready  output  1  stream word accepted this cycle when s_valid=1
s_data  input  WIDTH  zeta word, flat-index order starting at k=1
wr_en  output  STAGE_CNT  one-hot bank write strobe, bit s = stage s
wr_addr  output  STAGE_CNT-1  offset within the selected bank
wr_data  output  WIDTH  word to write
busy  output  1  high in LOAD
done  output  1  high in DONE until the next start
err  output  1  sticky range error; see Optional Feature

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: state=IDLE, idx=1, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. Bank contents are not touched.
- FSM states: IDLE, LOAD, DONE.
- IDLE: s_ready=0. On start, go to LOAD with idx=1 and err cleared.
- LOAD: s_ready=1 combinationally from state, with no dependence on s_valid.
  - Accept = s_valid & s_ready.
  - On accept, register wr_en = onehot(stage(idx)), wr_addr = idx - 2^stage(idx), wr_data = s_data, then increment idx.
  - Write latency is exactly 1 cycle after accept. wr_en is 0 in every cycle that does not follow an accept.
  - Accepting the word at idx = 2^STAGE_CNT-1 moves to DONE. s_ready drops in that next cycle while the final write strobe is on the outputs.
  - Bubbles (s_valid=0) hold idx and produce no strobe.
- DONE: done=1, s_ready=0. start returns to LOAD (full reload, idx=1, done cleared the next cycle).
- start while in LOAD is ignored, with no restart.
- Word count is fixed at 2^STAGE_CNT-1. Stage 0 receives exactly one write at wr_addr=0. idx has STAGE_CNT bits and never wraps, because the FSM leaves LOAD first.
- Reset mid-LOAD: aborts immediately; outputs return to reset values asynchronously. Banks may hold a partial load, and a new start is required.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro ZETA_RANGE_CHECK_EN.
- Defined: each accepted word with s_data >= Q (from ntt_pkg) sets err. err stays set until the next start or rst. The word is still written.
- Undefined: no comparator is built and err is tied to 0. The port list is unchanged.

Decomposition:
- ntt_pkg supplies NTT_STAGE_CNT, DATA_WIDTH, Q. Add a loader_state_t enum (IDLE/LOAD/DONE) there so the bench can probe state.
- One sub-module, zeta_idx_decode: combinational priority encoder from flat idx to {stage one-hot, offset}. Also reused by the bench scoreboard.

Test Plan (all scenarios use STAGE_CNT=3, 7 words):
- Reset then start, then words 11,22,...,77 streamed back-to-back. Expected writes: (wr_en=001, addr 0, 11); (010, 0, 22); (010, 1, 33); (100, 0, 44); (100, 1, 55); (100, 2, 66); (100, 3, 77). Each write appears one cycle after its accept; done=1 and s_ready=0 after the last write.
- Same stream with s_valid deasserted every other cycle: same write sequence, and no wr_en pulses during bubbles.
- Extra start pulse during LOAD after the 3rd word: ignored; the remaining 4 writes continue at idx 4..7.
- rst asserted after the 4th accept: all outputs clear asynchronously and the FSM is in IDLE. A new start reloads from (001, 0).
- From DONE, start then 7 new words: full reload with an identical address sequence; done drops one cycle after start.
- With ZETA_RANGE_CHECK_EN defined, word 3 = Q: err rises the cycle after that accept and stays set through DONE. The word is still written to (010, 1). The next start clears err.
